// File: rtl/syn_pkg.sv
// Shared types and helpers for the synapse delay array.
// The optional overrun counters are enabled with SYN_OVERRUN_CNT_EN.
package syn_pkg;

  typedef enum logic {
    SYN_IDLE    = 1'b0,
    SYN_PENDING = 1'b1
  } syn_state_t;

  localparam int OVR_W = 8;

  // Width of the summed current: one guard bit plus log2(channels) growth.
  function automatic int cur_w(input int weight_w, input int num_ch);
    return weight_w + $clog2(num_ch) + 1;
  endfunction

endpackage

// File: rtl/synapse_channel.sv
// One synaptic channel: edge detect, IDLE/PENDING delay FSM, captured weight.
// Define SYN_OVERRUN_CNT_EN to add a saturating per-channel dropped-event counter.
module synapse_channel
  import syn_pkg::*;
#(
  parameter int DELAY_W  = 3,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spike_in,
  input  logic [DELAY_W-1:0]  delay,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                fire,
  output logic                spike_out,
  output logic [WEIGHT_W-1:0] wgt_l,
  output syn_state_t          state
`ifdef SYN_OVERRUN_CNT_EN
  ,
  input  logic                cfg_clr,
  output logic [OVR_W-1:0]    overrun_cnt
`endif
);

  syn_state_t          state_q;
  syn_state_t          state_d;
  logic                prev_q;
  logic [DELAY_W-1:0]  cnt_q;
  logic [WEIGHT_W-1:0] wgt_q;
  logic                edge_det;
  logic                cnt_zero;
  logic                accept;

  assign edge_det = spike_in & ~prev_q;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SYN_IDLE;
    else       state_q <= state_d;
  end

  // An edge on the firing cycle re-arms rather than returning to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYN_IDLE:    if (edge_det) state_d = SYN_PENDING;
      SYN_PENDING: if (cnt_zero && !edge_det) state_d = SYN_IDLE;
      default:     state_d = SYN_IDLE;
    endcase
  end

  always_comb begin
    fire   = 1'b0;
    accept = 1'b0;
    case (state_q)
      SYN_IDLE: accept = edge_det;
      SYN_PENDING: begin
        fire   = cnt_zero;
        accept = cnt_zero & edge_det;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      wgt_q     <= '0;
      spike_out <= 1'b0;
    end else begin
      prev_q    <= spike_in;
      spike_out <= fire;
      if (accept) begin
        cnt_q <= delay;
        wgt_q <= weight;
      end else if (state_q == SYN_PENDING && !cnt_zero) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign wgt_l = wgt_q;
  assign state = state_q;

`ifdef SYN_OVERRUN_CNT_EN
  logic drop;
  assign drop = (state_q == SYN_PENDING) & ~cnt_zero & edge_det;

  // A config write to this channel takes priority over a same-cycle drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              overrun_cnt <= '0;
    else if (cfg_clr)                       overrun_cnt <= '0;
    else if (drop && overrun_cnt != '1)     overrun_cnt <= overrun_cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/synapse_delay_array.sv
// NUM_CH programmable-delay synapses with a registered weighted-sum current.
// Define SYN_OVERRUN_CNT_EN to expose per-channel overrun counters.
module synapse_delay_array
  import syn_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DELAY_W    = 3,
  parameter int WEIGHT_W   = 4,
  parameter int RST_DELAY  = 2,
  parameter int RST_WEIGHT = 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CH-1:0]                            spike_in,
  input  logic                                         cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [DELAY_W-1:0]                           cfg_delay,
  input  logic [WEIGHT_W-1:0]                          cfg_weight,
  output logic [NUM_CH-1:0]                            spike_out,
  output logic signed [cur_w(WEIGHT_W, NUM_CH)-1:0]    current_out,
  output logic [NUM_CH-1:0]                            busy
`ifdef SYN_OVERRUN_CNT_EN
  ,
  output logic [NUM_CH*OVR_W-1:0]                      overrun_cnt
`endif
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CUR_W = cur_w(WEIGHT_W, NUM_CH);

  logic [NUM_CH-1:0]               fire;
  logic [NUM_CH-1:0][WEIGHT_W-1:0] wgt_l;
  logic signed [CUR_W-1:0]         sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DELAY_W-1:0]  delay_q;
    logic [WEIGHT_W-1:0] weight_q;
    logic                cfg_hit;
    syn_state_t          state;

    // Out-of-range channel indices match no channel and are ignored.
    assign cfg_hit = cfg_we && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        delay_q  <= DELAY_W'(RST_DELAY);
        weight_q <= WEIGHT_W'(RST_WEIGHT);
      end else if (cfg_hit) begin
        delay_q  <= cfg_delay;
        weight_q <= cfg_weight;
      end
    end

    synapse_channel #(
      .DELAY_W (DELAY_W),
      .WEIGHT_W(WEIGHT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .spike_in   (spike_in[i]),
      .delay      (delay_q),
      .weight     (weight_q),
      .fire       (fire[i]),
      .spike_out  (spike_out[i]),
      .wgt_l      (wgt_l[i]),
      .state      (state)
`ifdef SYN_OVERRUN_CNT_EN
      ,
      .cfg_clr    (cfg_hit),
      .overrun_cnt(overrun_cnt[i*OVR_W +: OVR_W])
`endif
    );

    assign busy[i] = (state == SYN_PENDING);
  end

  // Sum of captured weights for channels firing this cycle, sign-extended.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fire[i]) sum = sum + {{(CUR_W-WEIGHT_W){wgt_l[i][WEIGHT_W-1]}}, wgt_l[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) current_out <= '0;
    else       current_out <= sum;
  end

endmodule

// File: tb/tb_synapse_delay_array.sv
// Table-driven bench for synapse_delay_array, plus hand sequences for reset
// mid-delay and out-of-range config writes. Checks overruns when SYN_OVERRUN_CNT_EN.
module tb_synapse_delay_array;

  typedef struct {
    logic [3:0] si;
    logic       we;
    logic [1:0] ch;
    logic [2:0] d;
    logic [3:0] w;
    logic [3:0] so;
    logic [6:0] cur;
    logic [3:0] bz;
    logic [7:0] ov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] spike_in;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_delay;
  logic [3:0] cfg_weight;
  logic [3:0] spike_out;
  logic [6:0] current_out;
  logic [3:0] busy;

  logic [2:0] s3_spike_in;
  logic       s3_we;
  logic [1:0] s3_ch;
  logic [2:0] s3_delay;
  logic [3:0] s3_weight;
  logic [2:0] s3_spike_out;
  logic [6:0] s3_current;
  logic [2:0] s3_busy;

`ifdef SYN_OVERRUN_CNT_EN
  logic [31:0] overrun_cnt;
  logic [23:0] s3_overrun_cnt;
`endif

  int tests = 0;
  int fails = 0;
  vec_t vecs[$];

  synapse_delay_array #(
    .NUM_CH(4), .DELAY_W(3), .WEIGHT_W(4), .RST_DELAY(2), .RST_WEIGHT(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_delay  (cfg_delay),
    .cfg_weight (cfg_weight),
    .spike_out  (spike_out),
    .current_out(current_out),
    .busy       (busy)
`ifdef SYN_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  synapse_delay_array #(
    .NUM_CH(3), .DELAY_W(3), .WEIGHT_W(4), .RST_DELAY(2), .RST_WEIGHT(1)
  ) dut3 (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (s3_spike_in),
    .cfg_we     (s3_we),
    .cfg_ch     (s3_ch),
    .cfg_delay  (s3_delay),
    .cfg_weight (s3_weight),
    .spike_out  (s3_spike_out),
    .current_out(s3_current),
    .busy       (s3_busy)
`ifdef SYN_OVERRUN_CNT_EN
    ,
    .overrun_cnt(s3_overrun_cnt)
`endif
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] si, input logic we, input logic [1:0] ch,
                              input logic [2:0] d, input logic [3:0] w, input logic [3:0] so,
                              input logic [6:0] cur, input logic [3:0] bz, input logic [7:0] ov);
    vec_t v;
    v.si = si; v.we = we; v.ch = ch; v.d = d; v.w = w;
    v.so = so; v.cur = cur; v.bz = bz; v.ov = ov;
    return v;
  endfunction

  task automatic add(input logic [3:0] si, input logic we, input logic [1:0] ch,
                     input logic [2:0] d, input logic [3:0] w, input logic [3:0] so,
                     input logic [6:0] cur, input logic [3:0] bz, input logic [7:0] ov);
    vecs.push_back(mk(si, we, ch, d, w, so, cur, bz, ov));
  endtask

  task automatic idle(input int n, input logic [3:0] bz, input logic [7:0] ov);
    repeat (n) add(4'b0, 1'b0, 2'd0, 3'd0, 4'd0, 4'b0, 7'd0, bz, ov);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [2:0] d, input logic [3:0] w, input logic [7:0] ov);
    add(4'b0, 1'b1, ch, d, w, 4'b0, 7'd0, 4'b0, ov);
  endtask

  // Drive one cycle of inputs, let the edge consume them, then compare outputs.
  task automatic apply(input vec_t v, input int idx);
    spike_in   = v.si;
    cfg_we     = v.we;
    cfg_ch     = v.ch;
    cfg_delay  = v.d;
    cfg_weight = v.w;
    @(posedge clk);
    #1;
    chk("spike_out", idx, {28'd0, spike_out}, {28'd0, v.so});
    chk("current_out", idx, {25'd0, current_out}, {25'd0, v.cur});
    chk("busy", idx, {28'd0, busy}, {28'd0, v.bz});
`ifdef SYN_OVERRUN_CNT_EN
    chk("overrun_cnt0", idx, {24'd0, overrun_cnt[7:0]}, {24'd0, v.ov});
`endif
  endtask

  initial begin
    reset = 1'b1;
    spike_in = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_weight = '0;
    s3_spike_in = '0; s3_we = 1'b0; s3_ch = '0; s3_delay = '0; s3_weight = '0;

    // Reset defaults: delay 2, weight 1; a held level is a single event.
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0000, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0001, 7'd1, 4'b0000, 8'd0);
    idle(1, 4'b0000, 8'd0);
    // ch1 delay 0 weight -3, ch2 delay 7 weight 5
    cfg(2'd1, 3'd0, 4'hD, 8'd0);
    cfg(2'd2, 3'd7, 4'h5, 8'd0);
    add(4'b0110, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0110, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b0010, 7'h7D, 4'b0100, 8'd0);
    idle(6, 4'b0100, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b0100, 7'd5, 4'b0000, 8'd0);
    // all channels delay 4, weight 7 then -8
    for (int c = 0; c < 4; c++) cfg(2'(c), 3'd4, 4'h7, 8'd0);
    add(4'b1111, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b1111, 8'd0);
    idle(4, 4'b1111, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b1111, 7'd28, 4'b0000, 8'd0);
    for (int c = 0; c < 4; c++) cfg(2'(c), 3'd4, 4'h8, 8'd0);
    add(4'b1111, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b1111, 8'd0);
    idle(4, 4'b1111, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b1111, 7'h60, 4'b0000, 8'd0);
    // ch0 delay 5 weight 2: overrun drop, then re-arm on the firing cycle
    cfg(2'd0, 3'd5, 4'h2, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd1);
    idle(3, 4'b0001, 8'd1);
    add(4'b0000, 0, 0, 0, 0, 4'b0001, 7'd2, 4'b0000, 8'd1);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd1);
    idle(5, 4'b0001, 8'd1);
    add(4'b0001, 0, 0, 0, 0, 4'b0001, 7'd2, 4'b0001, 8'd1);
    idle(5, 4'b0001, 8'd1);
    add(4'b0000, 0, 0, 0, 0, 4'b0001, 7'd2, 4'b0000, 8'd1);
    idle(1, 4'b0000, 8'd1);
    // config write on the accepting edge: old delay 2 / weight 3 used, then 1 / 4
    cfg(2'd0, 3'd2, 4'h3, 8'd0);
    add(4'b0001, 1, 0, 1, 4, 4'b0000, 7'd0, 4'b0001, 8'd0);
    idle(2, 4'b0001, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b0001, 7'd3, 4'b0000, 8'd0);
    add(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0);
    add(4'b0000, 0, 0, 0, 0, 4'b0001, 7'd4, 4'b0000, 8'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_spike_out", -1, {28'd0, spike_out}, 32'd0);
    chk("reset_busy", -1, {28'd0, busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset while a delay-6 spike is pending.
    apply(mk(4'b0000, 1, 0, 6, 1, 4'b0000, 7'd0, 4'b0000, 8'd0), 900);
    apply(mk(4'b0001, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0), 901);
    apply(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0), 902);
    apply(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b0001, 8'd0), 903);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 904, {28'd0, busy}, 32'd0);
    chk("async_reset_current", 904, {25'd0, current_out}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("post_reset_spike_out", 910 + i, {28'd0, spike_out}, 32'd0);
      chk("post_reset_busy", 910 + i, {28'd0, busy}, 32'd0);
    end
    // Defaults restored on every channel: delay 2, weight 1.
    apply(mk(4'b1111, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b1111, 8'd0), 940);
    apply(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b1111, 8'd0), 941);
    apply(mk(4'b0000, 0, 0, 0, 0, 4'b0000, 7'd0, 4'b1111, 8'd0), 942);
    apply(mk(4'b0000, 0, 0, 0, 0, 4'b1111, 7'd4, 4'b0000, 8'd0), 943);

    // Three-channel instance: cfg_ch=3 must not touch any channel.
    s3_we = 1'b1; s3_ch = 2'd3; s3_delay = 3'd0; s3_weight = 4'hF;
    @(posedge clk);
    #1;
    s3_we = 1'b0;
    s3_spike_in = 3'b111;
    @(posedge clk);
    #1;
    chk("ch3_busy_accept", 950, {29'd0, s3_busy}, {29'd0, 3'b111});
    chk("ch3_no_early_fire", 950, {29'd0, s3_spike_out}, 32'd0);
    s3_spike_in = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("ch3_no_early_fire", 951 + i, {29'd0, s3_spike_out}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("ch3_spike_out", 953, {29'd0, s3_spike_out}, {29'd0, 3'b111});
    chk("ch3_current", 953, {25'd0, s3_current}, 32'd3);
    chk("ch3_busy_done", 953, {29'd0, s3_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
